// File: rtl/icache_pkg.sv
// ============================================================================
// Module   : icache_pkg
// Brief    : Command codes, controller state encoding and command legality
//            check shared by the icache command controller files.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package icache_pkg;

    localparam logic [3:0] CMD_INST_FETCH = 4'd2;
    localparam logic [3:0] CMD_INVALIDATE = 4'd3;
    localparam logic [3:0] CMD_RESET      = 4'd8;
    localparam logic [3:0] CMD_PRINT      = 4'd9;
    localparam logic [3:0] CMD_NOP        = 4'd15;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_RESP = 2'd2,
        MISS_WAIT = 2'd3
    } icc_state_e;

    function automatic logic is_legal_maint(input logic [3:0] cmd);
        return (cmd == CMD_INVALIDATE) || (cmd == CMD_RESET) || (cmd == CMD_PRINT);
    endfunction

endpackage

`default_nettype wire

// File: rtl/icache_cmd_ctrl_if.sv
// ============================================================================
// Module   : icache_cmd_ctrl_if
// Brief    : Requester, cache and completion signals of icache_cmd_ctrl.
//            Statistics counters exist only when ICC_STATS_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface icache_cmd_ctrl_if #(
    parameter int ADDR_W = 32
);
    logic              f_valid;
    logic              f_ready;
    logic [ADDR_W-1:0] f_addr;
    logic              m_valid;
    logic              m_ready;
    logic [3:0]        m_cmd;
    logic [ADDR_W-1:0] m_addr;
    logic [3:0]        cache_n;
    logic [ADDR_W-1:0] cache_add;
    logic              cache_hit;
    logic              cache_miss;
    logic [ADDR_W-1:0] cache_add_out;
    logic              l2_req;
    logic [ADDR_W-1:0] l2_addr;
    logic              done;
    logic              done_src;
    logic              done_hit;
    logic              done_err;
`ifdef ICC_STATS_EN
    logic [31:0]       hit_cnt;
    logic [31:0]       miss_cnt;

    modport master (
        output f_valid, f_addr, m_valid, m_cmd, m_addr,
               cache_hit, cache_miss, cache_add_out,
        input  f_ready, m_ready, cache_n, cache_add, l2_req, l2_addr,
               done, done_src, done_hit, done_err, hit_cnt, miss_cnt
    );
    modport slave (
        input  f_valid, f_addr, m_valid, m_cmd, m_addr,
               cache_hit, cache_miss, cache_add_out,
        output f_ready, m_ready, cache_n, cache_add, l2_req, l2_addr,
               done, done_src, done_hit, done_err, hit_cnt, miss_cnt
    );
`else
    modport master (
        output f_valid, f_addr, m_valid, m_cmd, m_addr,
               cache_hit, cache_miss, cache_add_out,
        input  f_ready, m_ready, cache_n, cache_add, l2_req, l2_addr,
               done, done_src, done_hit, done_err
    );
    modport slave (
        input  f_valid, f_addr, m_valid, m_cmd, m_addr,
               cache_hit, cache_miss, cache_add_out,
        output f_ready, m_ready, cache_n, cache_add, l2_req, l2_addr,
               done, done_src, done_hit, done_err
    );
`endif
endinterface

`default_nettype wire

// File: rtl/icache_arb.sv
// ============================================================================
// Module   : icache_arb
// Brief    : Fetch/maintenance priority arbiter; maintenance wins unless it
//            has already won MAX_MAINT_RUN times in a row over a pending fetch.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module icache_arb #(
    parameter int MAX_MAINT_RUN = 4
) (
    input  wire logic clk,
    input  wire logic rst_n,
    input  wire logic i_en,
    input  wire logic i_f_valid,
    input  wire logic i_m_valid,
    output logic      o_grant,
    output logic      o_src
);
    localparam int c_RUN_W = $clog2(MAX_MAINT_RUN + 1);

    logic [c_RUN_W-1:0] r_run;
    logic               w_starve;

    assign w_starve = i_f_valid && (r_run == c_RUN_W'(MAX_MAINT_RUN));
    assign o_grant  = i_en && (i_f_valid || i_m_valid);
    assign o_src    = i_m_valid && !w_starve;

    // The run only matters while a fetch is actually waiting behind it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_run <= '0;
        end else if (!i_f_valid || (o_grant && !o_src)) begin
            r_run <= '0;
        end else if (o_grant && o_src) begin
            r_run <= r_run + 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/icache_cmd_ctrl.sv
// ============================================================================
// Module   : icache_cmd_ctrl
// Brief    : Serializes fetch and maintenance commands to the icache, tracks
//            hit/miss/timeout and reports one completion per request.
//            Optional hit/miss statistics: define ICC_STATS_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module icache_cmd_ctrl
    import icache_pkg::*;
#(
    parameter int ADDR_W        = 32,
    parameter int MISS_LAT      = 4,
    parameter int RESP_TIMEOUT  = 16,
    parameter int MAX_MAINT_RUN = 4
) (
    input wire logic          clk,
    input wire logic          rst_n,
    icache_cmd_ctrl_if.slave  bus
);
    localparam int c_LAT_W = $clog2(MISS_LAT + 1);
    localparam int c_TMO_W = $clog2(RESP_TIMEOUT + 1);

    icc_state_e        r_state;
    logic              r_src;
    logic              r_err;
    logic [3:0]        r_cache_n;
    logic [ADDR_W-1:0] r_cache_add;
    logic [ADDR_W-1:0] r_l2_addr;
    logic [c_LAT_W-1:0] r_lat_cnt;
    logic [c_TMO_W-1:0] r_tmo;

    logic w_idle, w_grant, w_gsrc, w_m_legal, w_in_wait;
    logic w_hit_only, w_miss_only, w_both, w_tmo, w_miss_done, w_maint_done;

    assign w_idle    = rst_n && (r_state == IDLE);
    assign w_m_legal = is_legal_maint(bus.m_cmd);

    icache_arb #(.MAX_MAINT_RUN(MAX_MAINT_RUN)) u_arb (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_en      (w_idle),
        .i_f_valid (bus.f_valid),
        .i_m_valid (bus.m_valid),
        .o_grant   (w_grant),
        .o_src     (w_gsrc)
    );

    assign bus.f_ready = w_grant && !w_gsrc;
    assign bus.m_ready = w_grant && w_gsrc;

    // Response decode is combinational so completion lands in the response cycle.
    assign w_in_wait    = rst_n && (r_state == WAIT_RESP);
    assign w_hit_only   = w_in_wait && bus.cache_hit && !bus.cache_miss;
    assign w_miss_only  = w_in_wait && bus.cache_miss && !bus.cache_hit;
    assign w_both       = w_in_wait && bus.cache_hit && bus.cache_miss;
    assign w_tmo        = w_in_wait && !bus.cache_hit && !bus.cache_miss &&
                          (r_tmo == c_TMO_W'(RESP_TIMEOUT - 1));
    assign w_miss_done  = rst_n && (r_state == MISS_WAIT) && (r_lat_cnt == '0);
    assign w_maint_done = rst_n && (r_state == ISSUE) && r_src;

    assign bus.done      = w_maint_done || w_hit_only || w_both || w_tmo || w_miss_done;
    assign bus.done_src  = r_src;
    assign bus.done_hit  = w_hit_only;
    assign bus.done_err  = (w_maint_done && r_err) || w_both || w_tmo;
    assign bus.l2_req    = w_miss_only;
    assign bus.l2_addr   = w_miss_only ? bus.cache_add_out : r_l2_addr;
    assign bus.cache_n   = r_cache_n;
    assign bus.cache_add = r_cache_add;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_src       <= 1'b0;
            r_err       <= 1'b0;
            r_cache_n   <= CMD_NOP;
            r_cache_add <= '0;
            r_l2_addr   <= '0;
            r_lat_cnt   <= '0;
            r_tmo       <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_grant) begin
                        r_state <= ISSUE;
                        r_src   <= w_gsrc;
                        if (w_gsrc) begin
                            // An illegal maintenance code never reaches the cache.
                            r_err       <= !w_m_legal;
                            r_cache_n   <= w_m_legal ? bus.m_cmd : CMD_NOP;
                            r_cache_add <= w_m_legal ? bus.m_addr : '0;
                        end else begin
                            r_err       <= 1'b0;
                            r_cache_n   <= CMD_INST_FETCH;
                            r_cache_add <= bus.f_addr;
                        end
                    end
                end
                ISSUE: begin
                    r_cache_n   <= CMD_NOP;
                    r_cache_add <= '0;
                    r_tmo       <= '0;
                    if (r_src) r_state <= IDLE;
                    else       r_state <= WAIT_RESP;
                end
                WAIT_RESP: begin
                    if (w_miss_only) begin
                        r_state   <= MISS_WAIT;
                        r_lat_cnt <= c_LAT_W'(MISS_LAT - 1);
                        r_l2_addr <= bus.cache_add_out;
                    end else if (w_hit_only || w_both || w_tmo) begin
                        r_state <= IDLE;
                    end else begin
                        r_tmo <= r_tmo + 1'b1;
                    end
                end
                MISS_WAIT: begin
                    if (r_lat_cnt == '0) r_state <= IDLE;
                    else                 r_lat_cnt <= r_lat_cnt - 1'b1;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

`ifdef ICC_STATS_EN
    logic [31:0] r_hit_cnt;
    logic [31:0] r_miss_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_hit_cnt  <= '0;
            r_miss_cnt <= '0;
        end else if (w_maint_done && (r_cache_n == CMD_RESET)) begin
            r_hit_cnt  <= '0;
            r_miss_cnt <= '0;
        end else begin
            if (w_hit_only && (r_hit_cnt != 32'hFFFF_FFFF))
                r_hit_cnt <= r_hit_cnt + 1'b1;
            if (w_miss_done && (r_miss_cnt != 32'hFFFF_FFFF))
                r_miss_cnt <= r_miss_cnt + 1'b1;
        end
    end

    assign bus.hit_cnt  = r_hit_cnt;
    assign bus.miss_cnt = r_miss_cnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_icache_cmd_ctrl.sv
// ============================================================================
// Module   : tb_icache_cmd_ctrl
// Brief    : Vector table plus completion scoreboard for icache_cmd_ctrl,
//            with arbitration and reset-during-miss sequences.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_icache_cmd_ctrl;
    import icache_pkg::*;

    localparam int MISS_LAT = 4;
    localparam int R_HIT  = 0;
    localparam int R_MISS = 1;
    localparam int R_BOTH = 2;
    localparam int R_NONE = 3;

    typedef struct {
        bit          is_m;
        logic [3:0]  cmd;
        logic [31:0] addr;
        int          resp;
        logic [31:0] maddr;
        logic [3:0]  exp_cn;
        int          exp_lat;
        bit          exp_hit;
        bit          exp_err;
    } vec_t;

    typedef struct {
        bit src;
        bit hit;
        bit err;
        int due;
    } sb_t;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;
    sb_t  sbq[$];
    vec_t vt[11];
    vec_t vfinal;
`ifdef ICC_STATS_EN
    int   exp_h = 0;
    int   exp_m = 0;
`endif

    icache_cmd_ctrl_if #(.ADDR_W(32)) bus ();

    icache_cmd_ctrl #(
        .ADDR_W(32), .MISS_LAT(MISS_LAT), .RESP_TIMEOUT(16), .MAX_MAINT_RUN(4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endfunction

    task automatic check_done();
        sb_t e;
        if (sbq.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL sb_underflow: done with nothing outstanding (cycle %0d)", cyc);
        end else begin
            e = sbq.pop_front();
            chk("done_cycle", cyc, e.due);
            chk("done_src", bus.done_src, e.src);
            chk("done_hit", bus.done_hit, e.hit);
            chk("done_err", bus.done_err, e.err);
        end
    endtask

    task automatic run_vec(input vec_t v);
        sb_t e;
        bit  granted;
        bit  got;
        int  t0;
        granted = 0;
        got = 0;
        t0 = 0;
        @(posedge clk); #1;
        if (v.is_m) begin
            bus.m_valid = 1'b1; bus.m_cmd = v.cmd; bus.m_addr = v.addr;
        end else begin
            bus.f_valid = 1'b1; bus.f_addr = v.addr;
        end
        for (int w = 0; w < 50 && !granted; w++) begin
            @(negedge clk);
            if ((v.is_m ? bus.m_ready : bus.f_ready) == 1'b1) granted = 1;
            else begin @(posedge clk); #1; end
        end
        chk("grant", granted, 1);
        if (granted) begin
            chk("loser_ready", v.is_m ? bus.f_ready : bus.m_ready, 0);
            t0 = cyc;
            e.src = v.is_m; e.hit = v.exp_hit; e.err = v.exp_err; e.due = t0 + v.exp_lat;
            sbq.push_back(e);
            for (int k = 1; k <= 40 && !got; k++) begin
                @(posedge clk); #1;
                if (k == 1) begin bus.f_valid = 1'b0; bus.m_valid = 1'b0; end
                bus.cache_hit     = (k == 2) && (v.resp == R_HIT || v.resp == R_BOTH);
                bus.cache_miss    = (k == 2) && (v.resp == R_MISS || v.resp == R_BOTH);
                bus.cache_add_out = v.maddr;
                @(negedge clk);
                if (k == 1) begin
                    chk("cache_n_issue", bus.cache_n, v.exp_cn);
                    if (v.exp_cn != CMD_NOP) chk("cache_add_issue", bus.cache_add, v.addr);
                end
                if (k == 2) begin
                    chk("cache_n_after", bus.cache_n, CMD_NOP);
                    chk("l2_req", bus.l2_req, v.resp == R_MISS);
                    if (v.resp == R_MISS) chk("l2_addr", bus.l2_addr, v.maddr);
                end
                if (bus.done) begin
                    got = 1;
                    check_done();
                end
            end
            chk("done_seen", got, 1);
        end
        bus.f_valid = 1'b0; bus.m_valid = 1'b0;
        bus.cache_hit = 1'b0; bus.cache_miss = 1'b0;
`ifdef ICC_STATS_EN
        if (!v.is_m && !v.exp_err) begin
            if (v.exp_hit) exp_h++;
            else           exp_m++;
        end
        if (v.is_m && v.cmd == CMD_RESET) begin exp_h = 0; exp_m = 0; end
        chk("hit_cnt", bus.hit_cnt, exp_h);
        chk("miss_cnt", bus.miss_cnt, exp_m);
`endif
    endtask

    initial begin : main
        int   order[6];
        int   exp_order[6];
        int   nseen;
        int   ndone;
        bit   granted;

        exp_order = '{1, 1, 1, 1, 0, 1};
        order     = '{-1, -1, -1, -1, -1, -1};
        bus.f_addr = '0; bus.m_cmd = '0; bus.m_addr = '0;
        bus.cache_hit = 1'b0; bus.cache_miss = 1'b0; bus.cache_add_out = '0;
        rst_n = 1'b0;
        bus.f_valid = 1'b1; bus.m_valid = 1'b1;

        // Reset state, with both requesters asking during reset.
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_f_ready", bus.f_ready, 0);
        chk("rst_m_ready", bus.m_ready, 0);
        chk("rst_cache_n", bus.cache_n, CMD_NOP);
        chk("rst_cache_add", bus.cache_add, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_l2_req", bus.l2_req, 0);
        chk("rst_l2_addr", bus.l2_addr, 0);
`ifdef ICC_STATS_EN
        chk("rst_hit_cnt", bus.hit_cnt, 0);
        chk("rst_miss_cnt", bus.miss_cnt, 0);
`endif
        @(posedge clk); #1;
        bus.f_valid = 1'b0; bus.m_valid = 1'b0;
        rst_n = 1'b1;

        //          is_m cmd   addr          resp    miss addr     exp_cn          lat hit err
        vt[0]  = '{0, 4'd2, 32'hFACEB00B, R_HIT,  32'h0,        CMD_INST_FETCH, 2,  1, 0};
        vt[1]  = '{0, 4'd2, 32'hDEADBEEF, R_MISS, 32'hDEADBEE0, CMD_INST_FETCH, 6,  0, 0};
        vt[2]  = '{0, 4'd2, 32'h00001000, R_HIT,  32'h0,        CMD_INST_FETCH, 2,  1, 0};
        vt[3]  = '{0, 4'd2, 32'h12345678, R_HIT,  32'h0,        CMD_INST_FETCH, 2,  1, 0};
        vt[4]  = '{1, 4'd8, 32'h00000000, R_NONE, 32'h0,        CMD_RESET,      1,  0, 0};
        vt[5]  = '{1, 4'd5, 32'h00000080, R_NONE, 32'h0,        CMD_NOP,        1,  0, 1};
        vt[6]  = '{1, 4'd3, 32'h00000040, R_NONE, 32'h0,        CMD_INVALIDATE, 1,  0, 0};
        vt[7]  = '{1, 4'd9, 32'h00000000, R_NONE, 32'h0,        CMD_PRINT,      1,  0, 0};
        vt[8]  = '{0, 4'd2, 32'hCAFE0000, R_NONE, 32'h0,        CMD_INST_FETCH, 17, 0, 1};
        vt[9]  = '{0, 4'd2, 32'h0BADF00D, R_BOTH, 32'h0,        CMD_INST_FETCH, 2,  0, 1};
        vt[10] = '{0, 4'd2, 32'hFFFFFFFF, R_MISS, 32'hFFFFFFC0, CMD_INST_FETCH, 6,  0, 0};

        for (int i = 0; i < 11; i++) run_vec(vt[i]);

        // Both requesters held high: the fetch wins after four maintenance grants.
        nseen = 0;
        @(posedge clk); #1;
        bus.m_cmd = CMD_PRINT; bus.m_addr = '0; bus.f_addr = 32'h00000100;
        bus.cache_hit = 1'b1;
        bus.f_valid = 1'b1; bus.m_valid = 1'b1;
        for (int c = 0; c < 200 && nseen < 6; c++) begin
            @(negedge clk);
            if (bus.m_ready) begin order[nseen] = 1; nseen++; end
            else if (bus.f_ready) begin order[nseen] = 0; nseen++; end
            @(posedge clk); #1;
        end
        bus.f_valid = 1'b0; bus.m_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1 bus.cache_hit = 1'b0;
        for (int i = 0; i < 6; i++) chk($sformatf("arb_order_%0d", i), order[i], exp_order[i]);
`ifdef ICC_STATS_EN
        exp_h++;
        chk("arb_hit_cnt", bus.hit_cnt, exp_h);
`endif

        // Reset in the middle of a miss penalty.
        granted = 0;
        @(posedge clk); #1;
        bus.f_valid = 1'b1; bus.f_addr = 32'h12340000;
        for (int w = 0; w < 50 && !granted; w++) begin
            @(negedge clk);
            if (bus.f_ready) granted = 1;
            else begin @(posedge clk); #1; end
        end
        chk("rstmiss_grant", granted, 1);
        @(posedge clk); #1;
        bus.f_valid = 1'b0;
        @(posedge clk); #1;
        bus.cache_miss = 1'b1; bus.cache_add_out = 32'h12340040;
        @(negedge clk);
        chk("rstmiss_l2_req", bus.l2_req, 1);
        @(posedge clk); #1;
        bus.cache_miss = 1'b0;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("rstmiss_cache_n", bus.cache_n, CMD_NOP);
        chk("rstmiss_cache_add", bus.cache_add, 0);
        chk("rstmiss_l2_addr", bus.l2_addr, 0);
        ndone = bus.done ? 1 : 0;
        repeat (MISS_LAT + 2) begin
            @(negedge clk);
            if (bus.done) ndone++;
        end
        chk("rstmiss_no_done", ndone, 0);
`ifdef ICC_STATS_EN
        exp_h = 0; exp_m = 0;
        chk("rstmiss_miss_cnt", bus.miss_cnt, 0);
`endif
        vfinal = '{0, 4'd2, 32'h00002000, R_HIT, 32'h0, CMD_INST_FETCH, 2, 1, 0};
        run_vec(vfinal);

        chk("sb_drained", sbq.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/icache_cmd_ctrl.md
# icache_cmd_ctrl

Command controller that sits in front of the instruction cache and serializes every cache operation. Two requesters share it: the fetch port, for instruction fetches from the trace front end, and the maintenance port, for invalidate, reset and print. The block arbitrates between them and drives the cache's 4-bit command code and address. It then waits for the cache's hit/miss response, models the miss penalty to the next level, and reports one completion per accepted request.

## Interface
- ADDR_W, 32, address width
- MISS_LAT, 4, cycles charged after a miss (>=1)
- RESP_TIMEOUT, 16, cycles to wait for hit/miss before flagging an error
- MAX_MAINT_RUN, 4, consecutive maintenance grants allowed while fetch is pending
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- f_valid / f_ready  in/out  1  fetch request handshake
- f_addr  in  ADDR_W  fetch address
- m_valid / m_ready  in/out  1  maintenance request handshake
- m_cmd  in  4  maintenance command (3 invalidate, 8 reset, 9 print)
- m_addr  in  ADDR_W  invalidate address
- cache_n  out  4  command to cache (15 = NOP)
- cache_add  out  ADDR_W  address to cache
- cache_hit / cache_miss  in  1  cache response
- cache_add_out  in  ADDR_W  cache miss address
- l2_req  out  1  one-cycle pulse on miss
- l2_addr  out  ADDR_W  registered cache_add_out
- done  out  1  completion pulse
- done_src  out  1  0 = fetch, 1 = maintenance
- done_hit  out  1  fetch hit (0 for maintenance)
- done_err  out  1  illegal command, timeout, or hit&miss
- hit_cnt / miss_cnt  out  32  statistics (ICC_STATS_EN only)

## Operation
- States: IDLE, ISSUE, WAIT_RESP, MISS_WAIT.
- IDLE: grant if any valid.
  - Maintenance wins by default.
  - Fetch wins if it is pending and the maintenance run count equals MAX_MAINT_RUN.
  - The granted ready is high combinationally in IDLE only; the other ready is 0.
  - On grant, latch cmd/addr and go to ISSUE.
  - Fetch command = 2.
- ISSUE: cache_n = latched cmd, cache_add = latched addr, for exactly one cycle.
  - Fetch goes to WAIT_RESP.
  - Legal maintenance pulses done and returns to IDLE.
  - Illegal m_cmd is never driven to the cache: cache_n stays 15, done with done_err=1.
- WAIT_RESP: sample hit/miss.
  - Hit only: done, done_hit=1, go IDLE.
  - Miss only: l2_req pulse, l2_addr = cache_add_out, go MISS_WAIT with counter = MISS_LAT-1.
  - Both: done, done_err=1, go IDLE.
  - Neither for RESP_TIMEOUT cycles: done, done_err=1, go IDLE.
- MISS_WAIT: count down; at 0 pulse done with done_hit=0, go IDLE.
- Maintenance run counter: increments on each maintenance grant; clears on a fetch grant or when f_valid is low.
- Outside ISSUE: cache_n = 15, cache_add = 0.

## Timing
- Reset, asserted at any state including mid-miss: state IDLE, counters 0, all pulses 0, readies 0, cache_n = 15, cache_add = 0, l2_addr = 0, hit_cnt = miss_cnt = 0. No done is emitted for the aborted request.
- Grant at cycle T, issue at T+1.
- Fetch hit: done at T+2.
- Fetch miss: l2_req at T+2, done at T+2+MISS_LAT.
- Maintenance: done at T+1.
- Next grant no earlier than the cycle after done; at most one outstanding request.
- Both valid in the same IDLE cycle: arbitration rule above; the loser keeps its valid and is not dropped.

## Configuration
- ICC_STATS_EN defined:
  - hit_cnt and miss_cnt are present, count on fetch done (hit or miss), and saturate at 2^32-1.
  - Both clear on a maintenance reset command (8).
  - Errored requests do not count.
- ICC_STATS_EN undefined: the counter ports and logic are absent.

## Structure
- Shared package icache_pkg:
  - Command constants CMD_INST_FETCH=2, CMD_INVALIDATE=3, CMD_RESET=8, CMD_PRINT=9, CMD_NOP=15.
  - State enum.
  - Legal-maintenance-command function.
- One sub-module, icache_arb: two-requester priority arbiter with the run-length starvation guard. It outputs grant and the winning source.

## Test plan
- Fetch 0xFACEB00B, cache answers hit at T+2 -> cache_n=2 at T+1 only; done/done_hit=1 at T+2; hit_cnt=1.
- Fetch 0xDEADBEEF, miss with cache_add_out=0xDEADBEE0, MISS_LAT=4 -> l2_req and l2_addr=0xDEADBEE0 at T+2; done, done_hit=0 at T+6; miss_cnt=1.
- m_valid and f_valid held high together for 6 requests, MAX_MAINT_RUN=4 -> grant order M,M,M,M,F,M.
- Maintenance cmd 8 after 3 hits -> cache_n=8 one cycle, done_src=1, hit_cnt=0; m_cmd=5 -> cache_n stays 15, done_err=1.
- Fetch with no response for 16 cycles -> done_err=1 at ISSUE+16, then IDLE. Hit&miss asserted together -> done_err=1.
- rst_n low during MISS_WAIT -> next cycle IDLE, cache_n=15, no done; a new fetch is accepted after release.
